// File: rtl/hdmi_timing_rx.sv
// rtl/hdmi_timing_rx.sv - HDMI sink timing monitor: pixel coordinates, line/frame geometry, frame checksum, mode lock
`timescale 1ns/1ps
module hdmi_timing_rx #(
  parameter int CNT_W       = 12,
  parameter int EXP_H_ACT   = 1280,
  parameter int EXP_H_TOT   = 1650,
  parameter int EXP_V_ACT   = 720,
  parameter int EXP_V_TOT   = 750,
  parameter int LOCK_FRAMES = 2,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  input  logic [7:0]       rgb_r,
  input  logic [7:0]       rgb_g,
  input  logic [7:0]       rgb_b,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] v_total,
  output logic [23:0]      frame_sum,
  output logic             frame_done,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_HA  = CNT_W'(EXP_H_ACT);
  localparam logic [CNT_W-1:0] EXP_HT  = CNT_W'(EXP_H_TOT);
  localparam logic [CNT_W-1:0] EXP_VA  = CNT_W'(EXP_V_ACT);
  localparam logic [CNT_W-1:0] EXP_VT  = CNT_W'(EXP_V_TOT);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;

  logic             s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
  logic [23:0]      s1_rgb;
  logic [CNT_W-1:0] h_cnt, de_run, v_hs_cnt, v_de_cnt;
  logic [23:0]      sum_acc;
  logic [3:0]       match_cnt;
  logic             first_line;

  logic hs_edge, vs_edge, de_rise, de_fall, frame_match;

  assign hs_edge = s1_hs & ~s2_hs;
  assign vs_edge = s1_vs & ~s2_vs;
  assign de_rise = s1_de & ~s2_de;
  assign de_fall = ~s1_de & s2_de;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // A saturated count means the true value is unknown, so it can never match.
  function automatic logic meas_ok(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] e);
    return (v == e) && (v != CNT_MAX);
  endfunction

  assign frame_match = meas_ok(h_active, EXP_HA) && meas_ok(h_total, EXP_HT) &&
                       meas_ok(v_de_cnt, EXP_VA) && meas_ok(v_hs_cnt, EXP_VT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_de      <= 1'b0;
      s2_hs      <= 1'b0;
      s2_vs      <= 1'b0;
      s2_de      <= 1'b0;
      s1_rgb     <= '0;
      h_cnt      <= '0;
      de_run     <= '0;
      v_hs_cnt   <= '0;
      v_de_cnt   <= '0;
      sum_acc    <= '0;
      match_cnt  <= '0;
      first_line <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
      h_active   <= '0;
      h_total    <= '0;
      v_active   <= '0;
      v_total    <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      s1_hs      <= (hs == 1'(HS_POL));
      s1_vs      <= (vs == 1'(VS_POL));
      s1_de      <= de;
      s1_rgb     <= {rgb_r, rgb_g, rgb_b};
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_de      <= s1_de;
      pix_valid  <= s1_de;
      frame_done <= 1'b0;
      err        <= 1'b0;

      if (de_rise)
        pix_x <= '0;
      else if (s1_de)
        pix_x <= sat_inc(pix_x);

      if (de_rise)
        pix_y <= (first_line || vs_edge) ? '0 : sat_inc(pix_y);

      if (vs_edge)
        first_line <= ~de_rise;
      else if (de_rise)
        first_line <= 1'b0;

      if (hs_edge) begin
        h_cnt   <= '0;
        h_total <= sat_inc(h_cnt);
      end else begin
        h_cnt   <= sat_inc(h_cnt);
      end

      if (de_rise)
        de_run <= CNT_W'(1);
      else if (s1_de)
        de_run <= sat_inc(de_run);
      if (de_fall)
        h_active <= de_run;

      // Events coinciding with vs_edge are credited to the frame that starts here.
      if (vs_edge) begin
        v_hs_cnt <= CNT_W'(hs_edge);
        v_de_cnt <= CNT_W'(de_rise);
        sum_acc  <= s1_de ? s1_rgb : 24'd0;
      end else begin
        if (hs_edge) v_hs_cnt <= sat_inc(v_hs_cnt);
        if (de_rise) v_de_cnt <= sat_inc(v_de_cnt);
        if (s1_de)   sum_acc  <= sum_acc + s1_rgb;
      end

      if (vs_edge) begin
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            v_total    <= v_hs_cnt;
            v_active   <= v_de_cnt;
            frame_sum  <= sum_acc;
            frame_done <= 1'b1;
            if (frame_match) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            v_total    <= v_hs_cnt;
            v_active   <= v_de_cnt;
            frame_sum  <= sum_acc;
            frame_done <= 1'b1;
            if (!frame_match) begin
              err       <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= MEASURE;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timing_rx.sv
// tb/tb_hdmi_timing_rx.sv - self-checking bench for hdmi_timing_rx
`timescale 1ns/1ps
module tb_hdmi_timing_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0] rgb_r = 8'd0, rgb_g = 8'd0, rgb_b = 8'd0;

  logic [11:0] pix_x, pix_y, h_active, h_total, v_active, v_total;
  logic [23:0] frame_sum;
  logic        pix_valid, frame_done, locked, err;

  logic [3:0]  pix_x4, pix_y4, h_active4, h_total4, v_active4, v_total4;
  logic [23:0] frame_sum4;
  logic        pix_valid4, frame_done4, locked4, err4;

  always #5 clk = ~clk;

  hdmi_timing_rx #(.CNT_W(12), .EXP_H_ACT(8), .EXP_H_TOT(12), .EXP_V_ACT(4), .EXP_V_TOT(6),
                   .LOCK_FRAMES(2), .HS_POL(1), .VS_POL(1)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
    .frame_sum(frame_sum), .frame_done(frame_done), .locked(locked), .err(err));

  hdmi_timing_rx #(.CNT_W(4), .EXP_H_ACT(8), .EXP_H_TOT(12), .EXP_V_ACT(4), .EXP_V_TOT(6),
                   .LOCK_FRAMES(2), .HS_POL(1), .VS_POL(1)) dut4 (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_x(pix_x4), .pix_y(pix_y4), .pix_valid(pix_valid4),
    .h_active(h_active4), .h_total(h_total4), .v_active(v_active4), .v_total(v_total4),
    .frame_sum(frame_sum4), .frame_done(frame_done4), .locked(locked4), .err(err4));

  typedef struct {
    int ht, ha, ds, vt, va, fa, mode;
    bit chk, exp_locked, exp_err;
    logic [23:0] exp_sum;
  } frame_vec_t;

  typedef struct {
    int cyc;
    int ht, ha, vt, va;
    logic [23:0] sum;
    bit locked, err;
    bit t_chk, t_locked, t_err;
    logic [23:0] t_sum;
  } ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit err4_seen = 0;
  bit chk_zero = 0;

  bit e_chk[4];
  bit e_valid[4];
  int e_x[4];
  int e_y[4];

  ev_t evq[$];
  bit  exp_locked = 0;

  // frame-level reference model state
  bit seen_vs = 0, m_locked = 0, pix_chk = 0;
  int run = 0;
  int cur_ht, cur_ha, cur_vt, cur_va;
  bit cur_tc, cur_tl, cur_te;
  logic [23:0] cur_ts, cur_sum;
  logic [7:0] ord;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat12(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic check_outputs();
    int s;
    s = (cyc + 2) % 4;
    if (frame_done) done_cnt++;
    if (err4) err4_seen = 1;
    if (chk_zero) begin
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_h_active", h_active, 0);
      chk("rst_h_total", h_total, 0);
      chk("rst_v_active", v_active, 0);
      chk("rst_v_total", v_total, 0);
      chk("rst_frame_sum", frame_sum, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk_zero = 0;
    end
    if (e_chk[s]) begin
      chk("pix_valid", pix_valid, e_valid[s]);
      if (e_valid[s]) begin
        chk("pix_x", pix_x, e_x[s]);
        chk("pix_y", pix_y, e_y[s]);
      end
    end
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      chk("frame_done", frame_done, 1);
      chk("h_total", h_total, evq[0].ht);
      chk("h_active", h_active, evq[0].ha);
      chk("v_total", v_total, evq[0].vt);
      chk("v_active", v_active, evq[0].va);
      chk("frame_sum", frame_sum, evq[0].sum);
      chk("err_pulse", err, evq[0].err);
      if (evq[0].t_chk) begin
        chk("tbl_locked", locked, evq[0].t_locked);
        chk("tbl_err", err, evq[0].t_err);
        chk("tbl_frame_sum", frame_sum, evq[0].t_sum);
      end
      exp_locked = evq[0].locked;
      void'(evq.pop_front());
    end else begin
      chk("frame_done_idle", frame_done, 0);
      chk("err_idle", err, 0);
    end
    chk("locked", locked, exp_locked);
  endtask

  // One pixel clock: check outputs of the drive two cycles ago, then apply new inputs.
  task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] c,
                      input int px, input int py, input bit r);
    @(negedge clk);
    check_outputs();
    hs = h; vs = v; de = d; rst = r;
    {rgb_r, rgb_g, rgb_b} = c;
    e_chk[cyc % 4]   = pix_chk;
    e_valid[cyc % 4] = d;
    e_x[cyc % 4]     = px;
    e_y[cyc % 4]     = py;
    if (r) begin
      e_chk[(cyc + 3) % 4] = 1; e_valid[(cyc + 3) % 4] = 0;
      e_chk[cyc % 4] = 1;       e_valid[cyc % 4] = 0;
      evq.delete();
      exp_locked = 0; seen_vs = 0; m_locked = 0; run = 0; pix_chk = 0;
      chk_zero = 1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 24'd0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 24'd0, 0, 0, 0);
  endtask

  // Close the previous frame in the model (if one was being measured) and open a new one.
  task automatic frame_start(input int ht, input int ha, input int vt, input int va,
                             input bit tc, input bit tl, input bit te, input logic [23:0] ts);
    ev_t e;
    bit match;
    if (seen_vs) begin
      e.cyc = cyc + 2;
      e.ht = sat12(cur_ht); e.ha = sat12(cur_ha); e.vt = sat12(cur_vt); e.va = sat12(cur_va);
      e.sum = cur_sum;
      match = (cur_ha == 8) && (cur_ht == 12) && (cur_va == 4) && (cur_vt == 6);
      if (match) begin
        run++;
        if (run >= 2) m_locked = 1;
        e.err = 0;
      end else begin
        e.err = m_locked;
        m_locked = 0;
        run = 0;
      end
      e.locked = m_locked;
      e.t_chk = cur_tc; e.t_locked = cur_tl; e.t_err = cur_te; e.t_sum = cur_ts;
      evq.push_back(e);
    end
    seen_vs = 1; pix_chk = 1;
    cur_ht = ht; cur_ha = ha; cur_vt = vt; cur_va = va;
    cur_tc = tc; cur_tl = tl; cur_te = te; cur_ts = ts;
    cur_sum = 24'd0; ord = 8'd0;
  endtask

  // Line: hs on cycles 0-1, de on [ds, ds+ha). Frame: vs on line 0, active lines [fa, fa+va).
  task automatic send_frame(input int ht, input int ha, input int ds, input int vt, input int va,
                            input int fa, input int mode, input bit tc, input bit tl, input bit te,
                            input logic [23:0] ts, input int rst_at);
    frame_start(ht, ha, vt, va, tc, tl, te, ts);
    for (int l = 0; l < vt; l++) begin
      for (int c = 0; c < ht; c++) begin
        logic d;
        logic [23:0] px;
        d = (l >= fa) && (l < fa + va) && (c >= ds) && (c < ds + ha);
        px = 24'd0;
        if (d) begin
          case (mode)
            0:       px = 24'h010203;
            1:       px = {ord, ord, ord};
            default: px = 24'($urandom);
          endcase
          cur_sum = cur_sum + px;
          ord = ord + 8'd1;
        end
        tick(c < 2, l == 0, d, px, c - ds, l - fa, (l * ht + c) == rst_at);
      end
    end
  endtask

  task automatic nominal(input int rst_at);
    send_frame(12, 8, 2, 6, 4, 1, 0, 0, 0, 0, 24'd0, rst_at);
  endtask

  frame_vec_t tbl[9];
  int mark;

  initial begin
    tbl[0] = '{12, 8, 2, 6, 4, 1, 0, 1, 0, 0, 24'h204060};
    tbl[1] = '{12, 8, 2, 6, 4, 1, 0, 1, 1, 0, 24'h204060};
    tbl[2] = '{12, 8, 2, 6, 4, 1, 1, 1, 1, 0, 24'hF1F1F0};
    tbl[3] = '{12, 7, 2, 6, 4, 1, 0, 1, 0, 1, 24'h1C3854};
    tbl[4] = '{12, 8, 2, 6, 4, 1, 0, 1, 0, 0, 24'h204060};
    tbl[5] = '{12, 8, 2, 6, 4, 1, 0, 1, 1, 0, 24'h204060};
    tbl[6] = '{12, 8, 0, 6, 4, 0, 0, 1, 1, 0, 24'h204060};
    tbl[7] = '{12, 8, 2, 6, 4, 1, 0, 1, 1, 0, 24'h204060};
    tbl[8] = '{12, 8, 2, 6, 4, 1, 0, 0, 0, 0, 24'h000000};

    do_reset();
    for (int i = 0; i < 9; i++)
      send_frame(tbl[i].ht, tbl[i].ha, tbl[i].ds, tbl[i].vt, tbl[i].va, tbl[i].fa, tbl[i].mode,
                 tbl[i].chk, tbl[i].exp_locked, tbl[i].exp_err, tbl[i].exp_sum, -1);

    // reset in the middle of an active line of a locked stream
    chk("locked_before_rst", locked, 1);
    nominal(2 * 12 + 5);
    mark = done_cnt;
    nominal(-1);
    chk("no_done_after_first_vs", done_cnt - mark, 0);
    nominal(-1);
    chk("first_done_after_second_vs", done_cnt - mark, 1);
    chk("not_locked_after_rst", locked, 0);

    // narrow counters: 20-clock lines saturate, 18-line frame saturates v_total
    do_reset();
    err4_seen = 0;
    repeat (3) send_frame(20, 8, 2, 6, 4, 1, 2, 0, 0, 0, 24'd0, -1);
    chk("cnt4_h_total_sat", h_total4, 15);
    chk("cnt4_locked", locked4, 0);
    send_frame(12, 8, 2, 18, 4, 1, 2, 0, 0, 0, 24'd0, -1);
    nominal(-1);
    chk("cnt4_v_total_sat", v_total4, 15);
    chk("cnt4_locked_end", locked4, 0);
    chk("cnt4_no_err", err4_seen, 0);

    // randomized geometry and pixels against the frame-level model
    do_reset();
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 9) < 7) begin
        send_frame(12, 8, int'($urandom_range(0, 3)), 6, 4, int'($urandom_range(0, 2)), 2,
                   0, 0, 0, 24'd0, -1);
      end else begin
        int ht, ha, vt, va;
        ht = int'($urandom_range(10, 16));
        ha = int'($urandom_range(6, 9));
        vt = int'($urandom_range(5, 8));
        va = int'($urandom_range(2, 4));
        send_frame(ht, ha, int'($urandom_range(0, ht - ha - 1)), vt, va,
                   int'($urandom_range(0, vt - va)), 2, 0, 0, 0, 24'd0, -1);
      end
    end
    repeat (4) tick(0, 0, 0, 24'd0, 0, 0, 0);
    chk("all_frame_events_seen", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
